store_retire_buffer: RTL and testbench

//  Post-retirement store buffer sitting between SQ retire port and D-cache write port.

---
 rtl/store_retire_buffer.sv | 103 ++++++++++
 tb/tb_store_retire_buffer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/store_retire_buffer.sv
// store_retire_buffer: in-order post-retire store FIFO draining to the D-cache with youngest-match load forwarding
module store_retire_buffer #(
  parameter int NUM_SUPER = 2,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 61,
  parameter int DATA_W    = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_SUPER-1:0]          st_wr_en,
  input  logic [NUM_SUPER*ADDR_W-1:0]   st_addr,
  input  logic [NUM_SUPER*DATA_W-1:0]   st_value,
  output logic [$clog2(DEPTH):0]        free_slots,
  output logic                          empty,
  output logic                          overflow_err,
  output logic                          mem_req_valid,
  output logic [ADDR_W-1:0]             mem_req_addr,
  output logic [DATA_W-1:0]             mem_req_data,
  input  logic                          mem_req_ready,
  input  logic [NUM_SUPER*ADDR_W-1:0]   ld_addr,
  output logic [NUM_SUPER-1:0]          ld_hit,
  output logic [NUM_SUPER*DATA_W-1:0]   ld_value
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d, room, npush;
  logic              ovf_q, ovf_d, pop;
  logic [NUM_SUPER-1:0] acc;
  logic [PTR_W-1:0]  slot [NUM_SUPER];
  assign room          = DEPTH_C - count_q;
  assign free_slots    = room;
  assign empty         = count_q == '0;
  assign overflow_err  = ovf_q;
  assign mem_req_valid = !empty;
  assign mem_req_addr  = mem_req_valid ? addr_q[head_q] : '0;
  assign mem_req_data  = mem_req_valid ? data_q[head_q] : '0;
  assign pop           = mem_req_valid && mem_req_ready;
  // Room is judged on the registered count, so a same-cycle pop never makes space for a push.
  always_comb begin
    acc   = '0;
    npush = '0;
    ovf_d = ovf_q;
    for (int l = 0; l < NUM_SUPER; l++) begin
      slot[l] = tail_q + npush[PTR_W-1:0];
      if (st_wr_en[l]) begin
        if (npush < room) begin
          acc[l] = 1'b1;
          npush  = npush + 1'b1;
        end else ovf_d = 1'b1;
      end
    end
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + npush[PTR_W-1:0];
    count_d = count_q + npush - CNT_W'(pop);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (pop) valid_q[head_q] <= 1'b0;
      for (int l = 0; l < NUM_SUPER; l++)
        if (acc[l]) begin
          addr_q[slot[l]]  <= st_addr[l*ADDR_W +: ADDR_W];
          data_q[slot[l]]  <= st_value[l*DATA_W +: DATA_W];
          valid_q[slot[l]] <= 1'b1;
        end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
  // Scan oldest to youngest so later matches override: buffered head..tail-1, then accepted lanes.
  always_comb begin
    ld_hit   = '0;
    ld_value = '0;
    for (int p = 0; p < NUM_SUPER; p++) begin
      for (int k = 0; k < DEPTH; k++)
        if (valid_q[head_q + PTR_W'(k)] && addr_q[head_q + PTR_W'(k)] == ld_addr[p*ADDR_W +: ADDR_W]) begin
          ld_hit[p]                   = 1'b1;
          ld_value[p*DATA_W +: DATA_W] = data_q[head_q + PTR_W'(k)];
        end
      for (int l = 0; l < NUM_SUPER; l++)
        if (acc[l] && st_addr[l*ADDR_W +: ADDR_W] == ld_addr[p*ADDR_W +: ADDR_W]) begin
          ld_hit[p]                   = 1'b1;
          ld_value[p*DATA_W +: DATA_W] = st_value[l*DATA_W +: DATA_W];
        end
    end
  end
endmodule

// File: tb/tb_store_retire_buffer.sv
// tb_store_retire_buffer: directed + constrained-random checks of the store retire buffer against a queue scoreboard
module tb_store_retire_buffer;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   st_wr_en = '0;
  logic [121:0] st_addr = '0;
  logic [127:0] st_value = '0;
  logic [3:0]   free_slots;
  logic         empty, overflow_err, mem_req_valid;
  logic [60:0]  mem_req_addr;
  logic [63:0]  mem_req_data;
  logic         mem_req_ready = 1'b0;
  logic [121:0] ld_addr = '0;
  logic [1:0]   ld_hit;
  logic [127:0] ld_value;
  int n_chk = 0, n_fail = 0, cnt_m = 0;
  logic ovf_m = 1'b0;
  logic [60:0] sb_a [$];
  logic [63:0] sb_d [$];

  store_retire_buffer dut (
    .clock(clock), .reset(reset), .st_wr_en(st_wr_en), .st_addr(st_addr), .st_value(st_value),
    .free_slots(free_slots), .empty(empty), .overflow_err(overflow_err),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_ready(mem_req_ready), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_value(ld_value)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] en, input logic [60:0] a0, input logic [63:0] v0,
                       input logic [60:0] a1, input logic [63:0] v1, input logic rdy);
    st_wr_en = en;
    st_addr  = {a1, a0};
    st_value = {v1, v0};
    mem_req_ready = rdy;
  endtask

  // One clock: check the head against the scoreboard, model the edge, then check registered state.
  task automatic tick();
    int np;
    logic pop;
    chk("mem_valid", 64'(mem_req_valid), 64'(cnt_m != 0));
    if (mem_req_valid && sb_a.size() > 0) begin
      chk("mem_addr", 64'(mem_req_addr), 64'(sb_a[0]));
      chk("mem_data", mem_req_data, sb_d[0]);
    end
    pop = (cnt_m != 0) && mem_req_ready;
    if (pop) begin
      void'(sb_a.pop_front());
      void'(sb_d.pop_front());
    end
    np = 0;
    for (int l = 0; l < 2; l++)
      if (st_wr_en[l]) begin
        if (np < 8 - cnt_m) begin
          sb_a.push_back(st_addr[l*61 +: 61]);
          sb_d.push_back(st_value[l*64 +: 64]);
          np++;
        end else ovf_m = 1'b1;
      end
    cnt_m = cnt_m + np - int'(pop);
    @(posedge clock);
    #1;
    st_wr_en = '0;
    chk("free_slots", 64'(free_slots), 64'(8 - cnt_m));
    chk("empty", 64'(empty), 64'(cnt_m == 0));
    chk("overflow_err", 64'(overflow_err), 64'(ovf_m));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    st_wr_en = '0;
    mem_req_ready = 1'b0;
    ld_addr = '0;
    cnt_m = 0;
    ovf_m = 1'b0;
    sb_a.delete();
    sb_d.delete();
    #1;
    chk("rst_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_addr", 64'(mem_req_addr), 64'd0);
    chk("rst_data", mem_req_data, 64'd0);
    chk("rst_ld_hit", 64'(ld_hit), 64'd0);
    chk("rst_ld_value", ld_value[63:0] | ld_value[127:64], 64'd0);
    chk("rst_free", 64'(free_slots), 64'd8);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_ovf", 64'(overflow_err), 64'd0);
  endtask

  task automatic drain();
    mem_req_ready = 1'b1;
    for (int i = 0; i < 30 && cnt_m != 0; i++) tick();
    chk("drain_done", 64'(cnt_m), 64'd0);
    chk("drain_sb", 64'(sb_a.size()), 64'd0);
  endtask

  initial begin
    int seq;
    logic [1:0] en;
    do_reset();
    // 1: single store, held while not ready, then popped
    drive(2'b01, 61'h10, 64'hAA, 61'h0, 64'h0, 1'b0);
    tick();
    repeat (3) tick();
    mem_req_ready = 1'b1;
    tick();
    chk("t1_empty", 64'(empty), 64'd1);
    // 2: same-address pair, lane 1 is youngest and forwards same cycle
    ld_addr = {61'h0, 61'h20};
    drive(2'b11, 61'h20, 64'h1, 61'h20, 64'h2, 1'b0);
    #1;
    chk("t2_hit", 64'(ld_hit[0]), 64'd1);
    chk("t2_value", ld_value[63:0], 64'h2);
    tick();
    drain();
    // 3: fill, then push with ready while full -> dropped, overflow, head popped
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 61'(16'h100 + 2*i), 64'(2*i), 61'(16'h101 + 2*i), 64'(2*i + 1), 1'b0);
      tick();
    end
    chk("t3_full", 64'(free_slots), 64'd0);
    drive(2'b01, 61'h1FF, 64'hDEAD, 61'h0, 64'h0, 1'b1);
    ld_addr = {61'h0, 61'h1FF};
    #1;
    chk("t3_drop_nofwd", 64'(ld_hit[0]), 64'd0);
    tick();
    chk("t3_ovf", 64'(overflow_err), 64'd1);
    chk("t3_count7", 64'(free_slots), 64'd1);
    drain();
    do_reset();
    // 4: mixed push/pop with ready toggling, enough traffic to wrap pointers twice
    seq = 0;
    for (int i = 0; i < 40; i++) begin
      en = 2'($urandom_range(0, 3));
      if (8 - cnt_m < 2) en = (8 - cnt_m == 1) ? (en & 2'b01) : 2'b00;
      drive(en, 61'(16'h400 + seq), 64'(32'hC000 + seq), 61'(16'h401 + seq), 64'(32'hC001 + seq), 1'((i % 3) != 0));
      seq += 2;
      tick();
    end
    drain();
    chk("t4_no_ovf", 64'(overflow_err), 64'd0);
    // 5: youngest buffered match wins
    drive(2'b11, 61'h30, 64'h5, 61'h40, 64'h6, 1'b0);
    tick();
    drive(2'b01, 61'h30, 64'h7, 61'h0, 64'h0, 1'b0);
    tick();
    ld_addr = {61'h40, 61'h30};
    #1;
    chk("t5_hit30", 64'(ld_hit[0]), 64'd1);
    chk("t5_val30", ld_value[63:0], 64'h7);
    chk("t5_hit40", 64'(ld_hit[1]), 64'd1);
    chk("t5_val40", ld_value[127:64], 64'h6);
    ld_addr = {61'h40, 61'h50};
    #1;
    chk("t5_hit50", 64'(ld_hit[0]), 64'd0);
    chk("t5_val50", ld_value[63:0], 64'h0);
    // 6: reset with 5 entries stalled
    drive(2'b11, 61'h60, 64'h8, 61'h70, 64'h9, 1'b0);
    tick();
    chk("t6_five", 64'(free_slots), 64'd3);
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
